// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one combinational ALU between two valid/ready requesters.
// Define ALU_ARB_FIXED_PRIO_EN to make requester 0 win every tie (no rr pointer).

`ifndef OP_ADD
`define OP_ADD 4'h0
`endif
`ifndef OP_SUB
`define OP_SUB 4'h1
`endif
`ifndef OP_BEQ
`define OP_BEQ 4'h8
`endif
`ifndef OP_BLT
`define OP_BLT 4'ha
`endif

module alu_share_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int OP_WIDTH   = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [1:0]            req_valid,
    output logic [1:0]            req_ready,
    input  logic [OP_WIDTH-1:0]   req_op_0,
    input  logic [OP_WIDTH-1:0]   req_op_1,
    input  logic [DATA_WIDTH-1:0] req_in1_0,
    input  logic [DATA_WIDTH-1:0] req_in1_1,
    input  logic [DATA_WIDTH-1:0] req_in2_0,
    input  logic [DATA_WIDTH-1:0] req_in2_1,
    output logic [1:0]            rsp_valid,
    input  logic [1:0]            rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_result_0,
    output logic [DATA_WIDTH-1:0] rsp_result_1,
    output logic                  rsp_bcond_0,
    output logic                  rsp_bcond_1,
    output logic [OP_WIDTH-1:0]   alu_op,
    output logic [DATA_WIDTH-1:0] alu_in_1,
    output logic [DATA_WIDTH-1:0] alu_in_2,
    input  logic [DATA_WIDTH-1:0] alu_result,
    input  logic                  alu_bcond,
    output logic [1:0]            alu_owner
);

    logic [1:0]            rsp_valid_q;
    logic [1:0]            rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_result_0_q;
    logic [DATA_WIDTH-1:0] rsp_result_0_d;
    logic [DATA_WIDTH-1:0] rsp_result_1_q;
    logic [DATA_WIDTH-1:0] rsp_result_1_d;
    logic                  rsp_bcond_0_q;
    logic                  rsp_bcond_0_d;
    logic                  rsp_bcond_1_q;
    logic                  rsp_bcond_1_d;

    logic [1:0] slot_free;
    logic [1:0] eligible;
    logic [1:0] grant;
    logic       prefer_1;

    // A full slot still accepts if it is being drained this same cycle.
    assign slot_free = ~rsp_valid_q | rsp_ready;
    assign eligible  = req_valid & slot_free;

`ifdef ALU_ARB_FIXED_PRIO_EN
    assign prefer_1 = 1'b0;
`else
    logic rr_ptr_q;
    logic rr_ptr_d;

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (grant[0]) begin
            rr_ptr_d = 1'b1;
        end else if (grant[1]) begin
            rr_ptr_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr_q <= 1'b0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign prefer_1 = rr_ptr_q;
`endif

    always_comb begin
        grant = 2'b00;
        if (eligible == 2'b11) begin
            grant = prefer_1 ? 2'b10 : 2'b01;
        end else begin
            grant = eligible;
        end
    end

    assign req_ready = grant;
    assign alu_owner = grant;

    always_comb begin
        alu_op   = OP_WIDTH'(`OP_ADD);
        alu_in_1 = '0;
        alu_in_2 = '0;
        unique case (1'b1)
            grant[0]: begin
                alu_op   = req_op_0;
                alu_in_1 = req_in1_0;
                alu_in_2 = req_in2_0;
            end
            grant[1]: begin
                alu_op   = req_op_1;
                alu_in_1 = req_in1_1;
                alu_in_2 = req_in2_1;
            end
            default: begin
            end
        endcase
    end

    // Result/bcond only load on a grant, so they hold while the slot stalls.
    always_comb begin
        rsp_valid_d    = rsp_valid_q & ~rsp_ready;
        rsp_result_0_d = rsp_result_0_q;
        rsp_result_1_d = rsp_result_1_q;
        rsp_bcond_0_d  = rsp_bcond_0_q;
        rsp_bcond_1_d  = rsp_bcond_1_q;
        if (grant[0]) begin
            rsp_valid_d[0] = 1'b1;
            rsp_result_0_d = alu_result;
            rsp_bcond_0_d  = alu_bcond;
        end
        if (grant[1]) begin
            rsp_valid_d[1] = 1'b1;
            rsp_result_1_d = alu_result;
            rsp_bcond_1_d  = alu_bcond;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rsp_valid_q    <= 2'b00;
            rsp_result_0_q <= '0;
            rsp_result_1_q <= '0;
            rsp_bcond_0_q  <= 1'b0;
            rsp_bcond_1_q  <= 1'b0;
        end else begin
            rsp_valid_q    <= rsp_valid_d;
            rsp_result_0_q <= rsp_result_0_d;
            rsp_result_1_q <= rsp_result_1_d;
            rsp_bcond_0_q  <= rsp_bcond_0_d;
            rsp_bcond_1_q  <= rsp_bcond_1_d;
        end
    end

    assign rsp_valid    = rsp_valid_q;
    assign rsp_result_0 = rsp_result_0_q;
    assign rsp_result_1 = rsp_result_1_q;
    assign rsp_bcond_0  = rsp_bcond_0_q;
    assign rsp_bcond_1  = rsp_bcond_1_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a small behavioural ALU.
// Tie expectations switch with ALU_ARB_FIXED_PRIO_EN.

`ifndef OP_ADD
`define OP_ADD 4'h0
`endif
`ifndef OP_SUB
`define OP_SUB 4'h1
`endif
`ifndef OP_BEQ
`define OP_BEQ 4'h8
`endif
`ifndef OP_BLT
`define OP_BLT 4'ha
`endif

module tb_alu_share_arbiter;

    logic        clk;
    logic        reset_n;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [3:0]  req_op_0;
    logic [3:0]  req_op_1;
    logic [31:0] req_in1_0;
    logic [31:0] req_in1_1;
    logic [31:0] req_in2_0;
    logic [31:0] req_in2_1;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready;
    logic [31:0] rsp_result_0;
    logic [31:0] rsp_result_1;
    logic        rsp_bcond_0;
    logic        rsp_bcond_1;
    logic [3:0]  alu_op;
    logic [31:0] alu_in_1;
    logic [31:0] alu_in_2;
    logic [31:0] alu_result;
    logic        alu_bcond;
    logic [1:0]  alu_owner;

    int total = 0;
    int bad   = 0;

    logic [1:0]  stall_q = 2'b00;
    logic [67:0] snap_q [2];

    alu_share_arbiter #(.DATA_WIDTH(32), .OP_WIDTH(4)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_op_0     (req_op_0),
        .req_op_1     (req_op_1),
        .req_in1_0    (req_in1_0),
        .req_in1_1    (req_in1_1),
        .req_in2_0    (req_in2_0),
        .req_in2_1    (req_in2_1),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_result_0 (rsp_result_0),
        .rsp_result_1 (rsp_result_1),
        .rsp_bcond_0  (rsp_bcond_0),
        .rsp_bcond_1  (rsp_bcond_1),
        .alu_op       (alu_op),
        .alu_in_1     (alu_in_1),
        .alu_in_2     (alu_in_2),
        .alu_result   (alu_result),
        .alu_bcond    (alu_bcond),
        .alu_owner    (alu_owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Branch ops produce in1-in2 as their result alongside the condition.
    always_comb begin
        alu_result = alu_in_1 + alu_in_2;
        alu_bcond  = 1'b0;
        case (alu_op)
            `OP_SUB: alu_result = alu_in_1 - alu_in_2;
            `OP_BEQ: begin
                alu_result = alu_in_1 - alu_in_2;
                alu_bcond  = (alu_in_1 == alu_in_2);
            end
            `OP_BLT: begin
                alu_result = alu_in_1 - alu_in_2;
                alu_bcond  = ($signed(alu_in_1) < $signed(alu_in_2));
            end
            default: begin
            end
        endcase
    end

    function automatic logic [67:0] fields(input int i);
        if (i == 0) return {req_op_0, req_in1_0, req_in2_0};
        return {req_op_1, req_in1_1, req_in2_1};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Also verifies the bench keeps stalled requests stable.
    task automatic tick();
        if (reset_n) begin
            for (int i = 0; i < 2; i++) begin
                if (stall_q[i] && req_valid[i]) begin
                    chk($sformatf("req%0d_hold", i), 64'(fields(i) != snap_q[i]), 64'd0);
                end
            end
        end
        stall_q   = req_valid & ~req_ready;
        snap_q[0] = fields(0);
        snap_q[1] = fields(1);
        @(posedge clk);
        #1;
    endtask

    logic [1:0]  exp_g3 [4];
    logic [31:0] exp_res1_t3;
    logic [1:0]  exp_g6a;
    logic [1:0]  exp_g6b;

    initial begin
`ifdef ALU_ARB_FIXED_PRIO_EN
        exp_g3      = '{2'b01, 2'b01, 2'b01, 2'b01};
        exp_res1_t3 = 32'hFFFF_FFFE;
        exp_g6a     = 2'b01;
        exp_g6b     = 2'b10;
`else
        exp_g3      = '{2'b01, 2'b10, 2'b01, 2'b10};
        exp_res1_t3 = 32'h0;
        exp_g6a     = 2'b10;
        exp_g6b     = 2'b01;
`endif
        reset_n   = 1'b0;
        req_valid = 2'b00;
        rsp_ready = 2'b00;
        req_op_0  = `OP_SUB;
        req_op_1  = `OP_SUB;
        req_in1_0 = 32'd0;
        req_in1_1 = 32'd0;
        req_in2_0 = 32'd0;
        req_in2_1 = 32'd0;

        repeat (2) @(negedge clk);
        chk("rst_rsp_valid", rsp_valid, 2'b00);
        chk("rst_req_ready", req_ready, 2'b00);
        chk("rst_owner", alu_owner, 2'b00);
        chk("rst_alu_op", alu_op, `OP_ADD);
        chk("rst_in1", alu_in_1, 0);
        chk("rst_in2", alu_in_2, 0);
        chk("rst_res0", rsp_result_0, 0);
        chk("rst_bcond1", rsp_bcond_1, 0);
        reset_n = 1'b1;

        tick();
        req_valid = 2'b01;
        rsp_ready = 2'b11;
        req_op_0  = `OP_ADD;
        req_in1_0 = 32'd5;
        req_in2_0 = 32'd7;
        @(negedge clk);
        chk("add_ready", req_ready, 2'b01);
        chk("add_owner", alu_owner, 2'b01);
        chk("add_in1", alu_in_1, 5);
        chk("add_in2", alu_in_2, 7);
        tick();
        req_valid = 2'b00;
        @(negedge clk);
        chk("add_rsp_valid", rsp_valid, 2'b01);
        chk("add_res0", rsp_result_0, 12);
        tick();
        @(negedge clk);
        chk("add_rsp_clear", rsp_valid, 2'b00);
        chk("idle_op", alu_op, `OP_ADD);

        tick();
        req_valid = 2'b10;
        req_op_1  = `OP_BLT;
        req_in1_1 = 32'hFFFF_FFFF;
        req_in2_1 = 32'd1;
        @(negedge clk);
        chk("blt_ready", req_ready, 2'b10);
        chk("blt_op", alu_op, `OP_BLT);
        tick();
        req_valid = 2'b00;
        @(negedge clk);
        chk("blt_rsp_valid", rsp_valid, 2'b10);
        chk("blt_bcond1", rsp_bcond_1, 1);
        chk("blt_res1", rsp_result_1, 32'hFFFF_FFFE);

        tick();
        req_valid = 2'b11;
        req_op_0  = `OP_SUB;
        req_in1_0 = 32'd10;
        req_in2_0 = 32'd3;
        req_op_1  = `OP_BEQ;
        req_in1_1 = 32'd4;
        req_in2_1 = 32'd4;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("rr_grant%0d", k), req_ready, exp_g3[k]);
            tick();
        end
        req_valid = 2'b00;
        @(negedge clk);
        chk("rr_res0", rsp_result_0, 7);
        chk("rr_bcond1", rsp_bcond_1, 1);
        chk("rr_res1", rsp_result_1, exp_res1_t3);

        tick();
        req_valid = 2'b01;
        rsp_ready = 2'b10;
        req_op_0  = `OP_ADD;
        req_in1_0 = 32'd100;
        req_in2_0 = 32'd23;
        @(negedge clk);
        chk("full_setup", req_ready, 2'b01);
        tick();
        req_valid = 2'b11;
        req_op_0  = `OP_SUB;
        req_in1_0 = 32'd50;
        req_in2_0 = 32'd8;
        req_op_1  = `OP_ADD;
        req_in1_1 = 32'd1;
        req_in2_1 = 32'd2;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("full_grant%0d", k), req_ready, 2'b10);
            chk($sformatf("full_res0_%0d", k), rsp_result_0, 123);
            chk($sformatf("full_valid0_%0d", k), rsp_valid[0], 1);
            tick();
        end
        rsp_ready = 2'b11;
        @(negedge clk);
        chk("drain_grant", req_ready, 2'b01);
        tick();
        req_valid = 2'b00;
        @(negedge clk);
        chk("drain_res0", rsp_result_0, 42);
        chk("drain_res1", rsp_result_1, 3);

        tick();
        req_valid = 2'b11;
        rsp_ready = 2'b00;
        @(negedge clk);
        chk("fill_grant_a", req_ready, exp_g6a);
        tick();
        @(negedge clk);
        chk("fill_grant_b", req_ready, exp_g6b);
        tick();
        @(negedge clk);
        chk("fill_valid", rsp_valid, 2'b11);
        chk("fill_stalled", req_ready, 2'b00);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_valid", rsp_valid, 2'b00);
        chk("async_res0", rsp_result_0, 0);
        chk("async_res1", rsp_result_1, 0);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("post_rst_grant", req_ready, 2'b01);
        chk("post_rst_in1", alu_in_1, 50);
        tick();
        @(negedge clk);
        chk("post_rst_valid", rsp_valid, 2'b01);
        chk("post_rst_res0", rsp_result_0, 42);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
